// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory.
// Optional MMIO block is enabled by defining DMEM_MMIO_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    AM_BYTE = 2'b00,
    AM_HALF = 2'b01,
    AM_WORD = 2'b10,
    AM_RSVD = 2'b11
  } access_mode_e;

  localparam logic [31:0] MMIO_BASE          = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_OFF_CYCLE     = 32'h0000_0000;
  localparam logic [31:0] MMIO_OFF_TOHOST    = 32'h0000_0004;
  localparam logic [31:0] MMIO_OFF_FAULTADDR = 32'h0000_0008;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: read extract with zero extension,
// write byte enables with data replication, misalignment detect.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]   i_addr_lo,
  input  access_mode_e i_mode,
  input  logic [31:0]  i_wdata,
  input  logic [31:0]  i_rword,
  output logic [31:0]  o_rdata,
  output logic [3:0]   o_be,
  output logic [31:0]  o_wdata,
  output logic         o_misaligned
);

  // Steer lanes according to access size; reserved mode is always misaligned
  always_comb begin
    o_rdata      = 32'd0;
    o_be         = 4'b0000;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_mode)
      AM_BYTE: begin
        o_rdata = {24'd0, i_rword[{i_addr_lo, 3'b000} +: 8]};
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      AM_HALF: begin
        o_rdata      = i_addr_lo[1] ? {16'd0, i_rword[31:16]} : {16'd0, i_rword[15:0]};
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      AM_WORD: begin
        o_rdata      = i_rword;
        o_be         = 4'b1111;
        o_misaligned = |i_addr_lo;
      end
      default: begin
        o_misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory for a single-cycle core: zero-latency reads, byte/half/word
// stores, sticky fault capture. Defining DMEM_MMIO_EN adds CYCLE, TOHOST
// and FAULTADDR word registers at 0xFFFF_0000.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic [1:0]  AccessMode,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic [31:0] FaultAddr,
  output logic        Halt,
  output logic [31:0] ToHost
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          r_fault;
  logic [31:0]   r_fault_addr;

  access_mode_e  w_mode;
  logic [AW-1:0] w_word_idx;
  logic [31:0]   w_rword;
  logic [31:0]   w_rdata_ram;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_misaligned;
  logic          w_in_ram;
  logic          w_mmio_hit;
  logic          w_illegal;
  logic          w_fault_evt;
  logic          w_ram_we;
  logic [31:0]   w_mmio_rdata;

  assign w_mode     = access_mode_e'(AccessMode);
  assign w_word_idx = ALUResult[AW+1:2];
  assign w_rword    = r_mem[w_word_idx];
  assign w_in_ram   = (ALUResult >> (AW + 2)) == 32'd0;

  dmem_lane_align u_align (
    .i_addr_lo    (ALUResult[1:0]),
    .i_mode       (w_mode),
    .i_wdata      (WriteData),
    .i_rword      (w_rword),
    .o_rdata      (w_rdata_ram),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

`ifdef DMEM_MMIO_EN
  logic        r_halt;
  logic [31:0] r_tohost;
  logic [31:0] r_cycle;
  logic        w_is_cycle;
  logic        w_is_tohost;
  logic        w_is_faultaddr;

  assign w_is_cycle     = ALUResult == (MMIO_BASE + MMIO_OFF_CYCLE);
  assign w_is_tohost    = ALUResult == (MMIO_BASE + MMIO_OFF_TOHOST);
  assign w_is_faultaddr = ALUResult == (MMIO_BASE + MMIO_OFF_FAULTADDR);
  // MMIO registers are word-only; narrower accesses fall through as illegal
  assign w_mmio_hit     = (w_is_cycle | w_is_tohost | w_is_faultaddr) & (w_mode == AM_WORD);

  // MMIO read mux
  always_comb begin
    w_mmio_rdata = 32'd0;
    if (w_is_cycle)     w_mmio_rdata = r_cycle;
    if (w_is_tohost)    w_mmio_rdata = r_tohost;
    if (w_is_faultaddr) w_mmio_rdata = r_fault_addr;
  end

  // Free-running cycle counter and first-write-wins TOHOST latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle  <= 32'd0;
      r_halt   <= 1'b0;
      r_tohost <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (MemWrite && w_mmio_hit && w_is_tohost && !r_halt) begin
        r_halt   <= 1'b1;
        r_tohost <= WriteData;
      end
    end
  end

  assign Halt   = r_halt;
  assign ToHost = r_tohost;
`else
  assign w_mmio_hit   = 1'b0;
  assign w_mmio_rdata = 32'd0;
  assign Halt         = 1'b0;
  assign ToHost       = 32'd0;
`endif

  assign w_illegal   = w_misaligned | ~(w_in_ram | w_mmio_hit);
  // A reserved-mode load is a no-op rather than an error
  assign w_fault_evt = w_illegal & (MemWrite | (w_mode != AM_RSVD));
  assign w_ram_we    = MemWrite & ~w_illegal & w_in_ram;

  // Zero-latency read data; illegal accesses read as zero
  always_comb begin
    ReadData = 32'd0;
    if (!w_illegal) begin
      if (w_in_ram) ReadData = w_rdata_ram;
      else          ReadData = w_mmio_rdata;
    end
  end

  // Byte-enabled RAM store; suppressed during reset, contents not reset
  always_ff @(posedge clk) begin
    if (!reset && w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_word_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Sticky fault flag; address captured only on the first fault
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else if (w_fault_evt) begin
      r_fault <= 1'b1;
      if (!r_fault) r_fault_addr <= ALUResult;
    end
  end

  assign Fault     = r_fault;
  assign FaultAddr = r_fault_addr;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp. Reference model is a byte array
// plus sticky fault/MMIO state derived from the access rules.
module tb_data_mem_resp;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [1:0]  AccessMode;
  logic [31:0] ReadData;
  logic        Fault;
  logic [31:0] FaultAddr;
  logic        Halt;
  logic [31:0] ToHost;

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResult  (ALUResult),
    .MemWrite   (MemWrite),
    .WriteData  (WriteData),
    .AccessMode (AccessMode),
    .ReadData   (ReadData),
    .Fault      (Fault),
    .FaultAddr  (FaultAddr),
    .Halt       (Halt),
    .ToHost     (ToHost)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // reference model state
  logic [7:0]  m_mem [NBYTES];
  logic        m_fault;
  logic [31:0] m_faddr;
  logic        m_halt;
  logic [31:0] m_tohost;
  logic [31:0] m_cycle;
  logic [31:0] last_rd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] mode);
    return (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a, input logic [1:0] mode);
`ifdef DMEM_MMIO_EN
    return (mode == 2'd2) && (a == 32'hFFFF_0000 || a == 32'hFFFF_0004 || a == 32'hFFFF_0008);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_illegal(input logic [31:0] a, input logic [1:0] mode);
    if (mode == 2'd3) return 1'b1;
    if (a % nbytes_of(mode) != 0) return 1'b1;
    if (is_mmio(a, mode)) return 1'b0;
    return a >= NBYTES;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] mode);
    logic [31:0] r;
    r = 32'd0;
    if (m_illegal(a, mode)) return 32'd0;
    if (is_mmio(a, mode)) begin
      if (a == 32'hFFFF_0000) return m_cycle;
      if (a == 32'hFFFF_0004) return m_tohost;
      return m_faddr;
    end
    for (int i = 0; i < nbytes_of(mode); i++) r = r | (32'(m_mem[a + i]) << (8 * i));
    return r;
  endfunction

  // driver: present one access, check combinational read, clock it, check state
  task automatic do_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] mode);
    MemWrite = we; ALUResult = a; WriteData = d; AccessMode = mode;
    @(negedge clk);
    last_rd = ReadData;
    chk("read_data", ReadData, m_read(a, mode));
    @(posedge clk);
    #1;
    if (m_illegal(a, mode)) begin
      if ((we || mode != 2'd3) && !m_fault) begin
        m_fault = 1'b1;
        m_faddr = a;
      end
    end else if (we) begin
      if (is_mmio(a, mode)) begin
        if (a == 32'hFFFF_0004 && !m_halt) begin
          m_halt = 1'b1;
          m_tohost = d;
        end
      end else begin
        for (int i = 0; i < nbytes_of(mode); i++) m_mem[a + i] = d[8*i +: 8];
      end
    end
    m_cycle = m_cycle + 1;
    MemWrite = 1'b0; ALUResult = 32'd0; AccessMode = 2'd2;
    chk("fault", {31'd0, Fault}, {31'd0, m_fault});
    chk("fault_addr", FaultAddr, m_faddr);
    chk("halt", {31'd0, Halt}, {31'd0, m_halt});
    chk("tohost", ToHost, m_tohost);
  endtask

  // reset for one edge, optionally with a store presented (must be suppressed)
  task automatic do_reset(input logic we, input logic [31:0] a, input logic [31:0] d);
    reset = 1'b1; MemWrite = we; ALUResult = a; WriteData = d; AccessMode = 2'd2;
    @(posedge clk);
    #1;
    reset = 1'b0; MemWrite = 1'b0; ALUResult = 32'd0;
    m_fault = 1'b0; m_faddr = 32'd0; m_halt = 1'b0; m_tohost = 32'd0; m_cycle = 32'd0;
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    chk("rst_fault_addr", FaultAddr, 32'd0);
    chk("rst_halt", {31'd0, Halt}, 32'd0);
    chk("rst_tohost", ToHost, 32'd0);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; ALUResult = 32'd0; WriteData = 32'd0; AccessMode = 2'd2;
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 32'd0, 32'd0);

    // define every RAM word
    for (int w = 0; w < DEPTH; w++) do_op(1'b1, 32'(w * 4), $urandom, 2'd2);

    // directed lane tests
    do_op(1'b1, 32'h10, 32'hDEADBEEF, 2'd2);
    do_op(1'b0, 32'h10, 32'd0, 2'd2);
    chk("word_load_10", last_rd, 32'hDEADBEEF);
    do_op(1'b0, 32'h11, 32'd0, 2'd0);
    chk("byte_load_11", last_rd, 32'h000000BE);
    do_op(1'b1, 32'h12, 32'h55, 2'd0);
    do_op(1'b0, 32'h12, 32'd0, 2'd1);
    chk("half_load_12", last_rd, 32'h0000DE55);
    do_op(1'b0, 32'h10, 32'd0, 2'd2);
    chk("word_load_10b", last_rd, 32'hDE55BEEF);
    // read-during-write shows old data, new data next cycle
    do_op(1'b1, 32'h10, 32'h01234567, 2'd2);
    do_op(1'b0, 32'h10, 32'd0, 2'd2);
    chk("rdw_next", last_rd, 32'h01234567);

    // random legal traffic
    for (int k = 0; k < 150; k++) begin
      logic [1:0]  md;
      logic [31:0] ad;
      md = 2'($urandom_range(0, 2));
      ad = 32'($urandom_range(0, NBYTES - 1));
      if (md == 2'd1) ad[0] = 1'b0;
      if (md == 2'd2) ad[1:0] = 2'b00;
      do_op(1'($urandom_range(0, 1)), ad, $urandom, md);
    end

    // misaligned store, then later fault keeps first address
    do_op(1'b1, 32'h22, 32'hCAFEF00D, 2'd2);
    chk("fault_addr_22", FaultAddr, 32'h22);
    do_op(1'b1, 32'h31, 32'h0000AAAA, 2'd1);
    chk("fault_addr_kept", FaultAddr, 32'h22);
    do_op(1'b0, 32'h20, 32'd0, 2'd2);
    do_op(1'b0, 32'h24, 32'd0, 2'd2);
    do_op(1'b0, 32'h30, 32'd0, 2'd2);

    // out-of-range store must not alias into RAM
    do_reset(1'b0, 32'd0, 32'd0);
    do_op(1'b1, 32'(NBYTES), 32'h12345678, 2'd2);
    chk("oor_fault", {31'd0, Fault}, 32'd1);
    do_op(1'b0, 32'(NBYTES), 32'd0, 2'd2);
    chk("oor_read_zero", last_rd, 32'd0);
    do_op(1'b0, 32'h0, 32'd0, 2'd2);

    // reset during store with fault set
    do_op(1'b1, 32'h40, 32'hA5A5_5A5A, 2'd2);
    do_reset(1'b1, 32'h40, 32'h1111_2222);
    do_op(1'b0, 32'h40, 32'd0, 2'd2);
    chk("rst_store_suppressed", last_rd, 32'hA5A5_5A5A);

    // random traffic including illegal accesses, periodic resets
    for (int k = 0; k < 90; k++) begin
      logic [31:0] ad;
      if (k % 30 == 0) do_reset(1'($urandom_range(0, 1)), 32'($urandom_range(0, NBYTES - 1)) & ~32'd3, $urandom);
      if ($urandom_range(0, 4) == 0) ad = 32'(NBYTES + $urandom_range(0, 63));
      else ad = 32'($urandom_range(0, NBYTES - 1));
      do_op(1'($urandom_range(0, 1)), ad, $urandom, 2'($urandom_range(0, 3)));
    end

`ifdef DMEM_MMIO_EN
    do_reset(1'b0, 32'd0, 32'd0);
    repeat (10) do_op(1'b0, 32'd0, 32'd0, 2'd2);
    do_op(1'b0, 32'hFFFF_0000, 32'd0, 2'd2);
    chk("cycle_10", last_rd, 32'd10);
    do_op(1'b1, 32'hFFFF_0000, 32'hFFFF_FFFF, 2'd2);
    do_op(1'b1, 32'hFFFF_0004, 32'h1, 2'd2);
    do_op(1'b1, 32'hFFFF_0004, 32'h2, 2'd2);
    chk("tohost_first", ToHost, 32'h1);
    chk("halt_set", {31'd0, Halt}, 32'd1);
    do_op(1'b0, 32'hFFFF_0004, 32'd0, 2'd2);
    do_op(1'b0, 32'hFFFF_0008, 32'd0, 2'd2);
    do_op(1'b0, 32'hFFFF_0004, 32'd0, 2'd0);
    chk("mmio_byte_fault", FaultAddr, 32'hFFFF_0004);
    do_op(1'b0, 32'hFFFF_0008, 32'd0, 2'd2);
`else
    do_reset(1'b0, 32'd0, 32'd0);
    do_op(1'b1, 32'hFFFF_0004, 32'h1, 2'd2);
    chk("no_mmio_halt", {31'd0, Halt}, 32'd0);
    chk("no_mmio_fault_addr", FaultAddr, 32'hFFFF_0004);
    do_op(1'b0, 32'hFFFF_0000, 32'd0, 2'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
